// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch/decode sequencer: drives the ROM address from the PC,
// latches the returned word into the instruction register, decodes it and
// issues one-cycle register-file / ALU control strobes until a HALT.
module instr_fetch_ctrl #(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 23,
  parameter int DATA_W  = 16,
  parameter int RA_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [INSTR_W-1:0] code,
  output logic [ADDR_W-1:0]  address,
  output logic [INSTR_W-1:0] ir,
  output logic [RA_W-1:0]    rf_ra_a,
  output logic [RA_W-1:0]    rf_ra_b,
  output logic               rf_we,
  output logic [RA_W-1:0]    rf_wa,
  output logic [1:0]         wr_sel,
  output logic [DATA_W-1:0]  imm,
  output logic [1:0]         alu_op,
  output logic               busy,
  output logic               done,
  output logic               illegal
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [3:0] OP_HALT = 4'b0000;
  localparam logic [3:0] OP_LOAD = 4'b0001;
  localparam logic [3:0] OP_MOV  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;

  localparam int RD_MSB = INSTR_W - 5;
  localparam int RS_MSB = RD_MSB - RA_W;

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;

  logic [3:0] opcode;
  logic       op_writes;
  logic       op_illegal;

  // Decode is taken from the instruction register only, never from code.
  assign opcode     = ir_q[INSTR_W-1 -: 4];
  assign op_writes  = (opcode == OP_LOAD) || (opcode == OP_MOV) ||
                      (opcode == OP_ADD)  || (opcode == OP_SUB);
  assign op_illegal = (opcode > OP_SUB);

  // State, program counter and instruction register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Sequencing: one instruction takes FETCH, DECODE, EXEC, WB; HALT stops in EXEC.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = code;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (opcode == OP_HALT) state_d = S_DONE;
        else                   state_d = S_WB;
      end
      S_WB: begin
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control outputs derived from state and the latched instruction.
  always_comb begin
    wr_sel = 2'b00;
    alu_op = 2'b00;
    case (opcode)
      OP_MOV: wr_sel = 2'b01;
      OP_ADD: wr_sel = 2'b10;
      OP_SUB: begin
        wr_sel = 2'b10;
        alu_op = 2'b01;
      end
      default: ;
    endcase
  end

  assign address = pc_q;
  assign ir      = ir_q;
  assign rf_ra_a = ir_q[RD_MSB -: RA_W];
  assign rf_ra_b = ir_q[RS_MSB -: RA_W];
  assign rf_wa   = ir_q[RD_MSB -: RA_W];
  assign imm     = ir_q[DATA_W-1:0];
  assign rf_we   = (state_q == S_WB) && op_writes;
  assign illegal = (state_q == S_EXEC) && op_illegal;
  assign busy    = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                   (state_q == S_EXEC)  || (state_q == S_WB);
  assign done    = (state_q == S_DONE);

endmodule
